// File: rtl/elevator_alert_controller.sv
// elevator_alert_controller
//   Multi-channel latched alert controller for the elevator car. Each channel
//   runs an independent IDLE/PENDING/ACTIVE/MUTED FSM that qualifies its
//   status input against a programmable hold threshold. The lowest-index
//   active alert drives alert_id.
//   Optional feature macro: ALERT_ESCALATE_EN adds per-channel escalation
//   counters. When the macro is undefined, escalate is tied to 0.
//
//   Handshake: status is a level and ack is a one-cycle pulse. There is no
//   ready/valid pairing. An ack counts only on the edge where the channel is
//   ACTIVE, and it is silently dropped in every other state.
module elevator_alert_controller #(
    parameter  int NUM_CH     = 4,
    parameter  int THRESH_W   = 8,
    parameter  int ESC_CYCLES = 1000,
    localparam int ID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            status,
    input  logic [NUM_CH*THRESH_W-1:0]   thresh,
    input  logic [NUM_CH-1:0]            ack,
    output logic [NUM_CH-1:0]            alert,
    output logic                         alert_any,
    output logic [ID_W-1:0]              alert_id,
    output logic [NUM_CH-1:0]            escalate,
    output logic [2*NUM_CH-1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_MUTED   = 2'd3
    } state_t;

    // Bad parameter values stop elaboration instead of building a broken block.
    if (NUM_CH < 1 || THRESH_W < 1 || ESC_CYCLES < 1) begin : g_param_check
        $error("elevator_alert_controller: NUM_CH, THRESH_W and ESC_CYCLES must be >= 1");
    end

    state_t              state_q [NUM_CH];
    state_t              state_d [NUM_CH];
    logic [THRESH_W-1:0] cnt_q   [NUM_CH];
    logic [THRESH_W-1:0] cnt_d   [NUM_CH];

    // Per-channel state and hold-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic. The live threshold is compared on every PENDING cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (status[i]) begin
                        if (thresh[i*THRESH_W +: THRESH_W] == '0) begin
                            state_d[i] = ST_ACTIVE;
                        end else begin
                            state_d[i] = ST_PENDING;
                            cnt_d[i]   = THRESH_W'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (!status[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= thresh[i*THRESH_W +: THRESH_W]) begin
                        state_d[i] = ST_ACTIVE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != '1) begin
                        cnt_d[i] = cnt_q[i] + THRESH_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    // The alert stays latched until it is acknowledged. The
                    // status level at the time of the ack picks IDLE or MUTED.
                    if (ack[i]) begin
                        state_d[i] = status[i] ? ST_MUTED : ST_IDLE;
                    end
                end
                ST_MUTED: begin
                    if (!status[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // The alert and debug outputs come straight from the state registers.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            alert[i]            = (state_q[i] == ST_ACTIVE);
            state_dbg[2*i +: 2] = state_q[i];
        end
    end

    // Summary decode: the lowest-index active channel wins.
    always_comb begin
        alert_any = |alert;
        alert_id  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (alert[i]) begin
                alert_id = ID_W'(i);
            end
        end
    end

`ifdef ALERT_ESCALATE_EN
    localparam int ESC_W = (ESC_CYCLES > 1) ? $clog2(ESC_CYCLES) : 1;

    logic [ESC_W-1:0]  esc_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] esc_q;

    // The escalation timer runs only while a channel stays ACTIVE. It starts
    // at 0 on entry and clears together with the flag when the channel leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                esc_cnt_q[i] <= '0;
            end
            esc_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state_q[i] != ST_ACTIVE || state_d[i] != ST_ACTIVE) begin
                    esc_cnt_q[i] <= '0;
                    esc_q[i]     <= 1'b0;
                end else if (esc_cnt_q[i] == ESC_W'(ESC_CYCLES - 1)) begin
                    esc_q[i] <= 1'b1;
                end else begin
                    esc_cnt_q[i] <= esc_cnt_q[i] + ESC_W'(1);
                end
            end
        end
    end

    assign escalate = esc_q;
`else
    assign escalate = '0;
`endif

endmodule

// File: tb/tb_elevator_alert_controller.sv
// tb_elevator_alert_controller
//   Directed bench for elevator_alert_controller using NUM_CH=4, THRESH_W=8
//   and ESC_CYCLES=20. The escalation expectations follow ALERT_ESCALATE_EN.
module tb_elevator_alert_controller;

    localparam int NUM_CH   = 4;
    localparam int THRESH_W = 8;
    localparam int ESC      = 20;
    localparam int ID_W     = 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_ACTIVE  = 2'd2;
    localparam logic [1:0] S_MUTED   = 2'd3;

`ifdef ALERT_ESCALATE_EN
    localparam logic [3:0] ESC0_EXP = 4'b0001;
`else
    localparam logic [3:0] ESC0_EXP = 4'b0000;
`endif

    logic                       clk;
    logic                       rst;
    logic [NUM_CH-1:0]          status;
    logic [NUM_CH*THRESH_W-1:0] thresh;
    logic [NUM_CH-1:0]          ack;
    logic [NUM_CH-1:0]          alert;
    logic                       alert_any;
    logic [ID_W-1:0]            alert_id;
    logic [NUM_CH-1:0]          escalate;
    logic [2*NUM_CH-1:0]        state_dbg;

    int checks;
    int errors;

    elevator_alert_controller #(
        .NUM_CH    (NUM_CH),
        .THRESH_W  (THRESH_W),
        .ESC_CYCLES(ESC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .status    (status),
        .thresh    (thresh),
        .ack       (ack),
        .alert     (alert),
        .alert_any (alert_any),
        .alert_id  (alert_id),
        .escalate  (escalate),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_thresh(input int ch, input int val);
        thresh[ch*THRESH_W +: THRESH_W] = THRESH_W'(val);
    endtask

    task automatic check_summary(input string tag, input logic [3:0] exp_alert,
                                 input logic exp_any, input logic [1:0] exp_id);
        check({tag, "_alert"}, 32'(alert), 32'(exp_alert));
        check({tag, "_any"},   32'(alert_any), 32'(exp_any));
        check({tag, "_id"},    32'(alert_id), 32'(exp_id));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        status = '0;
        ack    = '0;
        thresh = '0;

        // Reset state
        step(2);
        check_summary("reset", 4'b0000, 1'b0, 2'd0);
        check("reset_escalate", 32'(escalate), 32'h0);
        check("reset_state", 32'(state_dbg), 32'h0);
        rst = 1'b1;

        // Test 1: thresh0=5, so alert[0] rises after the 6th edge.
        set_thresh(0, 5);
        status[0] = 1'b1;
        step(1);
        check("t1_pending", 32'(state_dbg[1:0]), 32'(S_PENDING));
        step(4);
        check("t1_edge5_alert", 32'(alert), 32'h0);
        step(1);
        check_summary("t1_edge6", 4'b0001, 1'b1, 2'd0);
        // A status drop does not clear the latched alert.
        status[0] = 1'b0;
        step(1);
        check("t1_latched", 32'(alert), 32'b0001);
        // An ack with status low returns the channel straight to IDLE.
        ack[0] = 1'b1;
        step(1);
        ack[0] = 1'b0;
        check_summary("t1_ack", 4'b0000, 1'b0, 2'd0);
        check("t1_idle", 32'(state_dbg[1:0]), 32'(S_IDLE));

        // Test 2: a 4-cycle pulse against thresh=10 never alerts.
        set_thresh(1, 10);
        status[1] = 1'b1;
        step(4);
        check("t2_pend_alert", 32'(alert), 32'h0);
        check("t2_pend_state", 32'(state_dbg[3:2]), 32'(S_PENDING));
        status[1] = 1'b0;
        step(1);
        check("t2_idle", 32'(state_dbg[3:2]), 32'(S_IDLE));
        step(10);
        check("t2_no_alert", 32'(alert), 32'h0);

        // Test 3: thresh=0 alerts after one edge, then ACTIVE -> MUTED -> IDLE.
        set_thresh(2, 0);
        status[2] = 1'b1;
        step(1);
        check_summary("t3_active", 4'b0100, 1'b1, 2'd2);
        ack[2] = 1'b1;
        step(1);
        ack[2] = 1'b0;
        check("t3_muted_alert", 32'(alert), 32'h0);
        check("t3_muted_state", 32'(state_dbg[5:4]), 32'(S_MUTED));
        ack[2] = 1'b1;
        step(1);
        ack[2] = 1'b0;
        check("t3_muted_ack_ign", 32'(state_dbg[5:4]), 32'(S_MUTED));
        status[2] = 1'b0;
        step(1);
        check("t3_idle", 32'(state_dbg[5:4]), 32'(S_IDLE));
        ack[2] = 1'b1;
        step(1);
        ack[2] = 1'b0;
        check("t3_idle_ack_ign", 32'(state_dbg[5:4]), 32'(S_IDLE));
        check("t3_idle_alert", 32'(alert), 32'h0);

        // Test 4: with ch1 and ch3 both active, the lowest index wins.
        set_thresh(1, 2);
        set_thresh(3, 1);
        status[1] = 1'b1;
        status[3] = 1'b1;
        step(2);
        check_summary("t4_ch3", 4'b1000, 1'b1, 2'd3);
        step(1);
        check_summary("t4_both", 4'b1010, 1'b1, 2'd1);
        status[1] = 1'b0;
        status[3] = 1'b0;
        ack[1]    = 1'b1;
        step(1);
        ack[1] = 1'b0;
        check_summary("t4_ack1", 4'b1000, 1'b1, 2'd3);
        ack[3] = 1'b1;
        step(1);
        ack[3] = 1'b0;
        check_summary("t4_ack3", 4'b0000, 1'b0, 2'd0);

        // Test 5: escalation fires exactly ESC edges after the alert rose.
        set_thresh(0, 0);
        status[0] = 1'b1;
        step(1);
        check("t5_alert", 32'(alert), 32'b0001);
        step(ESC - 1);
        check("t5_esc_early", 32'(escalate), 32'h0);
        step(1);
        check("t5_esc", 32'(escalate), 32'(ESC0_EXP));
        step(3);
        check("t5_esc_held", 32'(escalate), 32'(ESC0_EXP));
        ack[0] = 1'b1;
        step(1);
        ack[0] = 1'b0;
        check("t5_ack_alert", 32'(alert), 32'h0);
        check("t5_ack_esc", 32'(escalate), 32'h0);
        check("t5_muted", 32'(state_dbg[1:0]), 32'(S_MUTED));
        status[0] = 1'b0;
        step(1);
        check("t5_idle", 32'(state_dbg[1:0]), 32'(S_IDLE));

        // Test 6: asynchronous reset while ch0 is PENDING and ch2 is ACTIVE.
        set_thresh(0, 5);
        set_thresh(2, 0);
        status[0] = 1'b1;
        status[2] = 1'b1;
        step(2);
        check("t6_pre_alert", 32'(alert), 32'b0100);
        check("t6_pre_ch0", 32'(state_dbg[1:0]), 32'(S_PENDING));
        rst = 1'b0;
        #2;
        check_summary("t6_async", 4'b0000, 1'b0, 2'd0);
        check("t6_async_state", 32'(state_dbg), 32'h0);
        check("t6_async_esc", 32'(escalate), 32'h0);
        status[2] = 1'b0;
        step(1);
        rst = 1'b1;
        // The hold count for ch0 restarts from zero after reset is released.
        step(5);
        check("t6_restart_edge5", 32'(alert), 32'h0);
        step(1);
        check_summary("t6_restart_edge6", 4'b0001, 1'b1, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
